// File: rtl/cpu_control_seq.sv
// Multi-cycle instruction sequencer: fetches into the instruction register, decodes
// the class and steps the decoder state code. Optional trap via CPU_ILLEGAL_TRAP_EN.
module cpu_control_seq #(
  parameter int COUNT_W       = 16,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               instr_valid,
  input  logic [22:0]        instr_in,
  output logic               instr_ready,
  output logic [22:0]        opcode,
  output logic [4:0]         state,
  output logic               alu_op,
  output logic               done,
  output logic               fetch_err,
  output logic [COUNT_W-1:0] instr_count
`ifdef CPU_ILLEGAL_TRAP_EN
  ,
  output logic               trap
`endif
);

  localparam logic [4:0] IDLE   = 5'b00000;
  localparam logic [4:0] LOAD   = 5'b00001;
  localparam logic [4:0] MOV    = 5'b00010;
  localparam logic [4:0] ARI1   = 5'b00011;
  localparam logic [4:0] ARI2   = 5'b00100;
  localparam logic [4:0] ARI3   = 5'b00101;
  localparam logic [4:0] FETCH  = 5'b00110;
  localparam logic [4:0] DECODE = 5'b00111;
  localparam logic [4:0] TRAP   = 5'b01000;

  localparam logic [2:0] C_LOAD = 3'b000;
  localparam logic [2:0] C_MOV  = 3'b001;
  localparam logic [2:0] C_ADD  = 3'b010;
  localparam logic [2:0] C_SUB  = 3'b011;
  localparam logic [2:0] C_NOP  = 3'b111;

`ifdef CPU_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] tmo_cnt;
  logic [2:0] cls;
  logic       cls_illegal;
  logic       complete;

  assign cls         = opcode[22:20];
  assign cls_illegal = (cls == 3'b100) || (cls == 3'b101) || (cls == 3'b110);
  assign instr_ready = (state == FETCH);

  // Final execute step of an instruction; nop (and untrapped illegal) finishes in DECODE.
  assign complete = (state == LOAD) || (state == MOV) || (state == ARI3) ||
                    ((state == DECODE) && ((cls == C_NOP) || (cls_illegal && !TRAP_EN)));

`ifdef CPU_ILLEGAL_TRAP_EN
  assign trap = (state == TRAP);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      opcode      <= '0;
      done        <= 1'b0;
      fetch_err   <= 1'b0;
      instr_count <= '0;
      alu_op      <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      done <= complete;
      if (complete) begin
        instr_count <= instr_count + 1'b1;
        state       <= run ? FETCH : IDLE;
      end else begin
        case (state)
          IDLE: if (run) state <= FETCH;
          FETCH: begin
            if (instr_valid) begin
              opcode  <= instr_in;
              tmo_cnt <= '0;
              state   <= DECODE;
            end else if (!run) begin
              tmo_cnt <= '0;
              state   <= IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
              fetch_err <= 1'b1;
              tmo_cnt   <= '0;
              state     <= IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          DECODE: begin
            case (cls)
              C_LOAD: state <= LOAD;
              C_MOV:  state <= MOV;
              C_ADD, C_SUB: begin
                state  <= ARI1;
                alu_op <= opcode[20];
              end
              default: if (TRAP_EN) state <= TRAP;
            endcase
          end
          ARI1: state <= ARI2;
          ARI2: state <= ARI3;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_control_seq.sv
// Bench for cpu_control_seq: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_cpu_control_seq;
  localparam int CW = 16;
  localparam int TO = 15;
  localparam logic [4:0] S_IDLE = 5'd0, S_LOAD = 5'd1, S_MOV = 5'd2, S_A1 = 5'd3, S_A2 = 5'd4,
                         S_A3 = 5'd5, S_FETCH = 5'd6, S_DEC = 5'd7, S_TRAP = 5'd8;
`ifdef CPU_ILLEGAL_TRAP_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic          clk, reset, run, instr_valid;
  logic [22:0]   instr_in;
  logic          instr_ready, alu_op, done, fetch_err;
  logic [22:0]   opcode;
  logic [4:0]    state;
  logic [CW-1:0] instr_count;
`ifdef CPU_ILLEGAL_TRAP_EN
  logic          trap;
`endif

  cpu_control_seq #(.COUNT_W(CW), .FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .instr_valid(instr_valid), .instr_in(instr_in),
    .instr_ready(instr_ready), .opcode(opcode), .state(state), .alu_op(alu_op),
    .done(done), .fetch_err(fetch_err), .instr_count(instr_count)
`ifdef CPU_ILLEGAL_TRAP_EN
    , .trap(trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-instruction plan of execute states held in a queue.
  logic [4:0]    m_state = S_IDLE;
  logic [22:0]   m_op = '0;
  logic          m_done = 1'b0, m_err = 1'b0, m_alu = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  int            m_tmo = 0;
  logic [4:0]    m_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_state = S_IDLE; m_op = '0; m_done = 0; m_err = 0; m_alu = 0; m_cnt = '0; m_tmo = 0;
      m_q.delete();
    end else begin
      m_done = 1'b0;
      case (m_state)
        S_IDLE: if (run) m_state = S_FETCH;
        S_FETCH: begin
          if (instr_valid) begin
            m_op = instr_in; m_tmo = 0; m_state = S_DEC;
            m_q.delete();
            case (instr_in[22:20])
              3'b000: m_q.push_back(S_LOAD);
              3'b001: m_q.push_back(S_MOV);
              3'b010, 3'b011: begin m_q.push_back(S_A1); m_q.push_back(S_A2); m_q.push_back(S_A3); end
              3'b111: ;
              default: if (TEN) m_q.push_back(S_TRAP);
            endcase
          end else if (!run) begin
            m_state = S_IDLE; m_tmo = 0;
          end else begin
            m_tmo++;
            if (m_tmo == TO) begin m_err = 1'b1; m_state = S_IDLE; m_tmo = 0; end
          end
        end
        S_TRAP: ;
        default: begin
          if (m_q.size() > 0) begin
            m_state = m_q.pop_front();
            if (m_state == S_A1) m_alu = m_op[20];
          end else begin
            m_done = 1'b1;
            m_cnt = m_cnt + 1'b1;
            m_state = run ? S_FETCH : S_IDLE;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_state));
    chk("opcode", 32'(opcode), 32'(m_op));
    chk("done", 32'(done), 32'(m_done));
    chk("fetch_err", 32'(fetch_err), 32'(m_err));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
    chk("alu_op", 32'(alu_op), 32'(m_alu));
    chk("instr_ready", 32'(instr_ready), 32'(m_state == S_FETCH));
`ifdef CPU_ILLEGAL_TRAP_EN
    chk("trap", 32'(trap), 32'(m_state == S_TRAP));
`endif
  end

  task automatic wait_state(input logic [4:0] s, input int lim, input string nm);
    int n = 0;
    while (state !== s && n < lim) begin @(negedge clk); n++; end
    if (state !== s) begin
      checks++; errors++;
      $display("FAIL %s: state %0h never reached, got %0h", nm, s, state);
    end
  endtask

  task automatic wait_done(input int lim, input string nm);
    int n = 0;
    while (done !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: done never pulsed, got %0b required 1", nm, done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndec, nari, na1, na3, nd, t, nf;
    int dc[2];
    logic alus[2];
    logic [CW-1:0] cnt0;

    reset = 1; run = 0; instr_valid = 0; instr_in = '0;
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_state", 32'(state), 32'(S_IDLE));
      chk("rst_ready", 32'(instr_ready), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_opcode", 32'(opcode), 32'd0);
    end

    // load
    run = 1; instr_valid = 1; instr_in = 23'h0A5000;
    @(negedge clk); chk("ld_s0", 32'(state), 32'(S_FETCH));
    @(negedge clk); chk("ld_s1", 32'(state), 32'(S_DEC)); chk("ld_op", 32'(opcode), 32'h0A5000);
    instr_valid = 0;
    @(negedge clk); chk("ld_s2", 32'(state), 32'(S_LOAD)); chk("ld_nodone", 32'(done), 32'd0);
    @(negedge clk); chk("ld_s3", 32'(state), 32'(S_FETCH)); chk("ld_done", 32'(done), 32'd1);
    chk("ld_cnt", 32'(instr_count), 32'd1);
    run = 0;
    @(negedge clk); chk("ld_idle", 32'(state), 32'(S_IDLE)); chk("ld_done1", 32'(done), 32'd0);

    // add then sub back-to-back
    cnt0 = instr_count;
    run = 1; instr_valid = 1; instr_in = 23'h250000;
    ndec = 0; nari = 0; na1 = 0; na3 = 0; nd = 0; t = 0; dc[0] = 0; dc[1] = 0; alus[0] = 1; alus[1] = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); t++;
      if (state == S_DEC) begin ndec++; if (ndec == 1) instr_in = 23'h3A3000; else instr_valid = 0; end
      if (state == S_A1) na1++;
      if (state == S_A3) na3++;
      if (state == S_A2 && nari < 2) begin alus[nari] = alu_op; nari++; end
      if (done && nd < 2) begin dc[nd] = t; nd++; if (nd == 2) run = 0; end
    end
    chk("ari_n2", 32'(nari), 32'd2);
    chk("ari_n1", 32'(na1), 32'd2);
    chk("ari_n3", 32'(na3), 32'd2);
    chk("alu_add", 32'(alus[0]), 32'd0);
    chk("alu_sub", 32'(alus[1]), 32'd1);
    chk("ari_ndone", 32'(nd), 32'd2);
    chk("ari_first_done", 32'(dc[0]), 32'd6);
    chk("ari_spacing", 32'(dc[1] - dc[0]), 32'd5);
    chk("ari_cnt", 32'(instr_count), 32'(cnt0 + 16'd2));

    // fetch timeout
    run = 1; instr_valid = 0; nf = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fetch_err) break;
      if (state == S_FETCH) nf++;
    end
    chk("tmo_cycles", 32'(nf), 32'(TO));
    chk("tmo_err", 32'(fetch_err), 32'd1);
    chk("tmo_state", 32'(state), 32'(S_IDLE));
    cnt0 = instr_count;
    instr_valid = 1; instr_in = 23'h1A0000;
    wait_done(10, "tmo_mov");
    instr_valid = 0; run = 0;
    chk("tmo_err_sticky", 32'(fetch_err), 32'd1);
    chk("tmo_mov_cnt", 32'(instr_count), 32'(cnt0 + 16'd1));

    // reset during ARI2
    @(negedge clk);
    reset = 1; @(negedge clk); reset = 0;
    run = 1; instr_valid = 1; instr_in = 23'h250000;
    wait_state(S_A2, 10, "rst_ari2");
    reset = 1; instr_valid = 0;
    @(negedge clk);
    chk("rmid_state", 32'(state), 32'(S_IDLE));
    chk("rmid_done", 32'(done), 32'd0);
    chk("rmid_cnt", 32'(instr_count), 32'd0);
    chk("rmid_alu", 32'(alu_op), 32'd0);
    reset = 0; run = 0;
    @(negedge clk);

    // illegal class
    run = 1; instr_valid = 1; instr_in = 23'h500000;
    wait_state(S_DEC, 5, "ill_dec");
    instr_valid = 0;
`ifdef CPU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run = i[0];
      chk("trap_state", 32'(state), 32'(S_TRAP));
      chk("trap_out", 32'(trap), 32'd1);
      chk("trap_nodone", 32'(done), 32'd0);
    end
    chk("trap_cnt", 32'(instr_count), 32'd0);
    reset = 1; @(negedge clk); reset = 0;
    chk("trap_rst", 32'(trap), 32'd0);
`else
    wait_done(5, "ill_nop");
    run = 0;
    chk("ill_cnt", 32'(instr_count), 32'd1);
    chk("ill_state", 32'(state), 32'(S_FETCH));
`endif
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_control_seq.md
Name: cpu_control_seq

Overview:
- Multi-cycle instruction sequencer for the simple CPU.
- Fetches an instruction word into the instruction register, decodes the operation class, and steps the 5-bit `state` code through the existing output-signal decoder.
- The decoder turns `state` plus `opcode` into tribuf/r_en/PC_step.
- Sits between the instruction source (memory/switches) and the decoder; owns `alu_op`, `done`, and a retired-instruction counter.

Parameters:
- COUNT_W, 16, width of retired-instruction counter.
- FETCH_TIMEOUT, 15, max cycles waiting in FETCH for instr_valid before flagging fetch_err (1..255).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  level; sequencer leaves IDLE and keeps issuing instructions while high.
- instr_valid  input  1  instruction source has a word on instr_in.
- instr_in  input  23  instruction word.
- instr_ready  output  1  high only in FETCH; word accepted when instr_valid&instr_ready.
- opcode  output  23  instruction register contents, fed to decoder.
- state  output  5  decoder state code.
- alu_op  output  1  0=add, 1=sub; valid during ARI2.
- done  output  1  one-cycle pulse when an instruction completes.
- fetch_err  output  1  sticky; set on fetch timeout, cleared by reset.
- instr_count  output  COUNT_W  instructions completed, wraps.

Behaviour:
- Reset (synchronous, active-high, wins over everything, including mid-instruction):
  - state=IDLE, opcode=0, done=0, fetch_err=0, instr_count=0, alu_op=0, timeout counter=0.
- State codes:
  - IDLE 00000, LOAD 00001, MOV 00010, ARI1 00011, ARI2 00100, ARI3 00101, FETCH 00110, DECODE 00111, TRAP 01000.
  - Codes ≥00110 decode to tribuf=0, r_en=0 in the downstream decoder.
- Operation class is opcode[22:20]:
  - 000 load
  - 001 mov
  - 010 add
  - 011 sub
  - 111 nop
  - other = illegal
- Transitions:
  - IDLE: run=1 -> FETCH, else stay.
  - FETCH: instr_ready=1. On instr_valid: opcode<=instr_in, timeout counter cleared, -> DECODE.
  - FETCH without instr_valid: timeout counter increments. On reaching FETCH_TIMEOUT, fetch_err<=1 and -> IDLE.
  - DECODE: class 000 -> LOAD; 001 -> MOV; 010/011 -> ARI1, alu_op<=opcode[20]; 111 -> complete; illegal -> see Optional Feature.
  - LOAD, MOV: one cycle each, then complete.
  - ARI1 -> ARI2 -> ARI3 -> complete. Arithmetic therefore takes 3 execute cycles.
- Complete: done=1 for exactly one cycle (the cycle after the final execute state), instr_count+=1 (wraps 2^COUNT_W-1 -> 0).
  - If run=1: -> FETCH in that same cycle.
  - Else: -> IDLE.
- Latency from accept to done:
  - load/mov: 3 cycles (DECODE, exec, done-cycle in FETCH/IDLE).
  - add/sub: 5 cycles.
  - nop: 2 cycles.
- run deasserted mid-instruction: the current instruction finishes; the sequencer stops only at completion.
- run deasserted in FETCH with no valid word: -> IDLE next cycle, no timeout flagged.
- If run falls and instr_valid is high in the same FETCH cycle, the word is accepted.
- opcode holds its value until the next accepted fetch; it never changes during execute states.
- fetch_err does not block further operation: a later run=1 re-enters FETCH.

Optional Feature:
- Macro: CPU_ILLEGAL_TRAP_EN.
- Defined:
  - An illegal class in DECODE -> TRAP. TRAP holds state=01000 until reset, ignores run, and produces no done and no count increment.
  - Adds output port trap (1 bit), high while in TRAP, 0 on reset.
- Undefined:
  - Illegal classes are executed as nop (done pulse, count increments).
  - No trap port; TRAP code is unreachable.

Test Plan:
- reset=1 for 2 cycles, then release with run=0 -> state=00000, opcode=0, instr_count=0, done=0, instr_ready=0 stays for 10 cycles.
- run=1, instr_valid=1, instr_in=23'h0A5000 (load) -> opcode=23'h0A5000 one cycle after accept.
  - state sequence: 00110, 00111, 00001, 00110.
  - done pulses once; instr_count=1.
- Add 23'h250000 then sub 23'h3A3000 back-to-back, instr_valid held high:
  - Each instruction passes through ARI1/ARI2/ARI3.
  - alu_op=0 then 1 during the respective ARI2.
  - instr_count=2; done pulses are 5 cycles apart.
- run=1, instr_valid=0 for FETCH_TIMEOUT=15 cycles -> fetch_err=1 on cycle 15, state returns to 00000. A subsequent valid fetch completes normally with fetch_err still 1.
- Reset asserted during ARI2 -> next cycle state=00000, done=0, count unchanged at 0.
- instr_in=23'h500000 (illegal):
  - With CPU_ILLEGAL_TRAP_EN: state=01000, trap=1, persisting for 20 cycles despite run toggling.
  - Without it: done pulse, instr_count increments by 1.
